// File: rtl/majority_voter_scrubbed_register_array.sv
// majority_voter_scrubbed_register_array: K_MMR-redundant register file with voted reads and a background scrubber.
// Define MAJORITY_VOTER_SCRUB_INJECT_EN to add single-bit fault-injection ports.
module majority_voter_scrubbed_register_array #(
  parameter int K_MMR = 3,
  parameter int N = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  parameter int PERIOD_W = 16,
  parameter logic [N-1:0] INIT_VALUE = '0,
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [N-1:0]        wr_data_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [N-1:0]        rd_data_o,
  input  logic                scrub_en_i,
  input  logic [PERIOD_W-1:0] scrub_period_i,
  input  logic                cnt_clr_i,
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
  input  logic                inj_en_i,
  input  logic [$clog2(K_MMR)-1:0] inj_copy_i,
  input  logic [ADDR_W-1:0]   inj_addr_i,
  input  logic [$clog2(N)-1:0] inj_bit_i,
`endif
  output logic                mismatch_o,
  output logic [CNT_W-1:0]    corrected_cnt_o,
  output logic                scrub_busy_o,
  output logic                scrub_done_o
);
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, FIX, ADVANCE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [K_MMR-1:0][N-1:0] mem_q [DEPTH];
  logic [K_MMR-1:0][N-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] rd_data_q, rd_data_d;
  logic [N-1:0] scrub_vote;
  logic scrub_diff, wr_ok, wr_hit, fix;

  function automatic logic [N-1:0] vote(input logic [K_MMR-1:0][N-1:0] c);
    int ones;
    vote = '0;
    for (int b = 0; b < N; b++) begin
      ones = 0;
      for (int k = 0; k < K_MMR; k++) ones += int'(c[k][b]);
      vote[b] = ones > K_MMR / 2;
    end
  endfunction

  assign scrub_vote = vote(mem_q[scrub_addr_q]);
  assign scrub_diff = mem_q[scrub_addr_q] != {K_MMR{scrub_vote}};
  assign wr_ok = wr_en_i && int'(wr_addr_i) < DEPTH;
  assign wr_hit = wr_ok && wr_addr_i == scrub_addr_q;
  // A write or injection landing between CHECK and FIX is re-evaluated here; only a real repair counts.
  assign fix = state_q == FIX && scrub_diff && !wr_hit;

  always_comb begin
    mem_d = mem_q;
    state_d = state_q;
    timer_d = timer_q;
    scrub_addr_d = scrub_addr_q;
    rd_data_d = int'(rd_addr_i) < DEPTH ? vote(mem_q[rd_addr_i]) : INIT_VALUE;
    case (state_q)
      IDLE: begin
        timer_d = scrub_en_i ? scrub_period_i : timer_q;
        state_d = !scrub_en_i ? IDLE : scrub_period_i == '0 ? CHECK : WAIT;
      end
      WAIT: begin
        timer_d = timer_q - 1'b1;
        state_d = !scrub_en_i ? IDLE : timer_q <= PERIOD_W'(1) ? CHECK : WAIT;
      end
      CHECK: state_d = scrub_diff ? FIX : ADVANCE;
      FIX: state_d = ADVANCE;
      ADVANCE: begin
        state_d = IDLE;
        scrub_addr_d = scrub_addr_q == LAST ? '0 : scrub_addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fix) mem_d[scrub_addr_q] = {K_MMR{scrub_vote}};
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
    if (inj_en_i && int'(inj_addr_i) < DEPTH && int'(inj_copy_i) < K_MMR && int'(inj_bit_i) < N)
      mem_d[inj_addr_i][inj_copy_i][inj_bit_i] = ~mem_d[inj_addr_i][inj_copy_i][inj_bit_i];
`endif
    if (wr_ok) mem_d[wr_addr_i] = {K_MMR{wr_data_i}};
    cnt_d = cnt_clr_i ? '0 : (fix && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      scrub_addr_q <= '0;
      cnt_q <= '0;
      rd_data_q <= INIT_VALUE;
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= {K_MMR{INIT_VALUE}};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      scrub_addr_q <= scrub_addr_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign corrected_cnt_o = cnt_q;
  assign mismatch_o = state_q == CHECK && scrub_diff;
  assign scrub_busy_o = state_q == CHECK || state_q == FIX;
  assign scrub_done_o = state_q == ADVANCE && scrub_addr_q == LAST;
endmodule

// File: tb/tb_majority_voter_scrubbed_register_array.sv
// tb_majority_voter_scrubbed_register_array: randomized scoreboard bench; read expectations come from a copy-level model.
module tb_majority_voter_scrubbed_register_array;
  localparam int K = 3;
  localparam int D = 6;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic clk_i = 0, rst_i = 1, wr_en_i = 0, scrub_en_i = 0, cnt_clr_i = 0;
  logic [2:0] wr_addr_i = 0, rd_addr_i = 0;
  logic [15:0] wr_data_i = 0, scrub_period_i = 0, rd_data_o;
  logic mismatch_o, scrub_busy_o, scrub_done_o;
  logic [1:0] corrected_cnt_o;
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
  logic inj_en_i = 0;
  logic [1:0] inj_copy_i = 0;
  logic [2:0] inj_addr_i = 0;
  logic [3:0] inj_bit_i = 0;
  int exp_cnt, m0;
`endif

  majority_voter_scrubbed_register_array #(
    .K_MMR(K), .N(16), .DEPTH(D), .CNT_W(2), .PERIOD_W(16), .INIT_VALUE(INIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .scrub_en_i(scrub_en_i), .scrub_period_i(scrub_period_i),
    .cnt_clr_i(cnt_clr_i),
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
    .inj_en_i(inj_en_i), .inj_copy_i(inj_copy_i), .inj_addr_i(inj_addr_i), .inj_bit_i(inj_bit_i),
`endif
    .mismatch_o(mismatch_o), .corrected_cnt_o(corrected_cnt_o), .scrub_busy_o(scrub_busy_o),
    .scrub_done_o(scrub_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; logic [2:0] addr; logic [15:0] data; } rd_t;
  rd_t exp_q[$];
  rd_t mon_e;
  logic [15:0] cp [D][K];
  int checks = 0, errors = 0, cyc = 0;
  int mis_cnt = 0, busy_cnt = 0, done_cnt = 0, last_done = 0, last_mis = 0;
  int c, b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] model_vote(input logic [2:0] a);
    logic [15:0] v = '0;
    int n;
    if (int'(a) >= D) return INIT;
    for (int b = 0; b < 16; b++) begin
      n = 0;
      for (int k = 0; k < K; k++) n += int'(cp[a][k][b]);
      v[b] = n > K / 2;
    end
    return v;
  endfunction

  task automatic model_fill(input logic [15:0] v);
    for (int a = 0; a < D; a++) for (int k = 0; k < K; k++) cp[a][k] = v;
  endtask

  task automatic model_scrub();
    logic [15:0] v;
    for (int a = 0; a < D; a++) begin
      v = model_vote(3'(a));
      for (int k = 0; k < K; k++) cp[a][k] = v;
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i) exp_q.delete();
    else begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        chk($sformatf("read_addr%0d", mon_e.addr), 32'(rd_data_o), 32'(mon_e.data));
      end
      if (mismatch_o) begin mis_cnt++; last_mis = cyc; end
      if (scrub_busy_o) busy_cnt++;
      if (scrub_done_o) begin done_cnt++; last_done = cyc; end
    end
  end

  task automatic step();
    rd_t e;
    e.due = cyc + 1;
    e.addr = rd_addr_i;
    e.data = model_vote(rd_addr_i);
    exp_q.push_back(e);
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
    if (inj_en_i && int'(inj_addr_i) < D && int'(inj_copy_i) < K && !(wr_en_i && wr_addr_i == inj_addr_i))
      cp[inj_addr_i][inj_copy_i][inj_bit_i] = ~cp[inj_addr_i][inj_copy_i][inj_bit_i];
`endif
    if (wr_en_i && int'(wr_addr_i) < D) for (int k = 0; k < K; k++) cp[wr_addr_i][k] = wr_data_i;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n0 = done_cnt;
    for (int t = 0; t < 3000 && done_cnt == n0; t++) begin
      rd_addr_i = 3'($urandom_range(0, 7));
      step();
    end
    if (done_cnt == n0) chk({name, "_timeout"}, 32'(done_cnt), 32'(n0 + 1));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #1;
    rst_i = 1;
    @(posedge clk_i);
    #1;
    chk("rst_rd_data", 32'(rd_data_o), 32'(INIT));
    chk("rst_cnt", 32'(corrected_cnt_o), 0);
    chk("rst_busy", 32'(scrub_busy_o), 0);
    model_fill(INIT);
    rst_i = 0;
  endtask

`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
  task automatic inj(input logic [2:0] a, input logic [1:0] k, input logic [3:0] b);
    inj_en_i = 1; inj_addr_i = a; inj_copy_i = k; inj_bit_i = b;
    step();
    inj_en_i = 0;
  endtask

  task automatic wait_mis(input string name);
    for (int t = 0; t < 500 && !mismatch_o; t++) begin
      rd_addr_i = 3'($urandom_range(0, 7));
      step();
    end
    if (!mismatch_o) chk({name, "_timeout"}, 32'(mismatch_o), 1);
  endtask
`endif

  initial begin
    model_fill(INIT);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rd_data", 32'(rd_data_o), 32'(INIT));
    chk("rst_cnt", 32'(corrected_cnt_o), 0);
    chk("rst_mismatch", 32'(mismatch_o), 0);
    chk("rst_done", 32'(scrub_done_o), 0);
    rd_addr_i = 3;
    rst_i = 0;
    step();
    wr_en_i = 1; wr_addr_i = 5; wr_data_i = 16'h1234; rd_addr_i = 0;
    step();
    wr_en_i = 0; rd_addr_i = 5;
    step();
    wr_en_i = 1; wr_data_i = 16'h5678;
    step();
    wr_en_i = 0;
    step();
    for (int i = 0; i < 300; i++) begin
      wr_en_i = 1'($urandom_range(0, 1));
      wr_addr_i = 3'($urandom_range(0, 7));
      wr_data_i = 16'($urandom);
      rd_addr_i = 3'($urandom_range(0, 7));
      step();
    end
    wr_en_i = 0;
    scrub_period_i = 0; scrub_en_i = 1; c = cyc; b0 = busy_cnt;
    wait_done("pass0");
    chk("done_first", 32'(last_done), 32'(c + 3 * D - 1));
    c = last_done;
    wait_done("pass1");
    chk("done_interval", 32'(last_done - c), 32'(3 * D));
    chk("busy_cycles", 32'(busy_cnt - b0), 32'(2 * D));
    chk("no_mismatch", 32'(mis_cnt), 0);
    chk("cnt_clean", 32'(corrected_cnt_o), 0);
    scrub_en_i = 0;
    step();
    scrub_period_i = 4; scrub_en_i = 1; c = cyc;
    wait_done("pass_p4");
    chk("done_p4", 32'(last_done), 32'(c + 7 * D - 1));
    scrub_period_i = 0;
    repeat (10) step();
    do_reset();
    c = cyc;
    wait_done("pass_rst");
    chk("done_after_rst", 32'(last_done), 32'(c + 3 * D - 1));
    scrub_en_i = 0;
    step();
`ifdef MAJORITY_VOTER_SCRUB_INJECT_EN
    wr_en_i = 1; wr_addr_i = 2; wr_data_i = 0;
    step();
    wr_en_i = 0;
    inj(2, 1, 0);
    rd_addr_i = 2;
    step();
    m0 = mis_cnt; scrub_period_i = 4; scrub_en_i = 1; c = cyc;
    wait_done("inj_pass");
    scrub_en_i = 0;
    step();
    model_scrub();
    exp_cnt = 1;
    chk("inj_mis_count", 32'(mis_cnt - m0), 1);
    chk("inj_mis_addr2", 32'(last_mis), 32'(c + 5 + 7 * 2));
    chk("inj_cnt", 32'(corrected_cnt_o), 32'(exp_cnt));
    inj(2, 2, 0);
    rd_addr_i = 2;
    step();
    wr_en_i = 1; wr_addr_i = 2; wr_data_i = 0;
    step();
    wr_en_i = 0;
    m0 = mis_cnt;
    for (int i = 0; i < 5; i++) inj(3'(i < 2 ? i : i + 1), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
    scrub_period_i = 0; scrub_en_i = 1;
    wait_done("sat_pass");
    scrub_en_i = 0;
    step();
    model_scrub();
    exp_cnt = exp_cnt + 5 > 3 ? 3 : exp_cnt + 5;
    chk("sat_mis_count", 32'(mis_cnt - m0), 5);
    chk("sat_cnt", 32'(corrected_cnt_o), 32'(exp_cnt));
    inj(1, 0, 3);
    scrub_en_i = 1;
    wait_mis("clr_mis");
    cnt_clr_i = 1;
    step();
    step();
    cnt_clr_i = 0;
    exp_cnt = 0;
    chk("clr_over_fix", 32'(corrected_cnt_o), 32'(exp_cnt));
    wait_done("clr_pass");
    scrub_en_i = 0;
    step();
    model_scrub();
    chk("clr_cnt_after", 32'(corrected_cnt_o), 32'(exp_cnt));
    inj(4, 2, 7);
    scrub_en_i = 1;
    wait_mis("col_mis");
    step();
    wr_en_i = 1; wr_addr_i = 4; wr_data_i = 16'hBEEF;
    step();
    wr_en_i = 0;
    chk("col_cnt", 32'(corrected_cnt_o), 32'(exp_cnt));
    wait_done("col_pass");
    scrub_en_i = 0;
    step();
    model_scrub();
    inj(4, 0, 0);
    rd_addr_i = 4;
    step();
    chk("col_cnt_after", 32'(corrected_cnt_o), 32'(exp_cnt));
`endif
    repeat (2) step();
    @(negedge clk_i);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
